twos_to_bipolar_serial: RTL and testbench

- Multi-lane streaming converter: accepts a vector of two's-complement or unsigned words per transaction.
- Splits each word into registered positive/negative magnitude planes (bipolar_p / bipolar_n).
- Emits the planes bit-serially, one bit-plane per handshake, with selectable order and truncated precision.
- Sits between the activation buffer and the bit-serial in-memory-compute array driver. Replaces the purely combinational converter where the array consumes one input bit per cycle.

---
 rtl/twos_to_bipolar_serial_if.sv | 37 +++
 rtl/twos_to_bipolar_serial.sv | 111 +++++++++++
 tb/tb_twos_to_bipolar_serial.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/twos_to_bipolar_serial_if.sv
// Handshake and data bundle for the bit-serial bipolar converter.
//
// Both streams use strict valid/ready semantics: a transfer happens on a
// rising clk edge where valid and ready are both high. The producer must hold
// valid and its payload stable until that transfer. Ready may depend
// combinationally on the other side's valid.
interface twos_to_bipolar_serial_if #(
  parameter int inBits   = 4,
  parameter int numLanes = 32,
  parameter int idxBits  = (inBits > 1) ? $clog2(inBits) : 1,
  parameter int precBits = $clog2(inBits + 1)
);
  logic                         in_valid;
  logic                         in_ready;
  logic [numLanes*inBits-1:0]   twos;
  logic                         unsigned_inputs;
  logic                         msb_first;
  logic [precBits-1:0]          precision;
  logic                         out_valid;
  logic                         out_ready;
  logic [numLanes-1:0]          plane_p;
  logic [numLanes-1:0]          plane_n;
  logic [idxBits-1:0]           bit_idx;
  logic                         first;
  logic                         last;
  logic                         busy;

  modport master (
    output in_valid, twos, unsigned_inputs, msb_first, precision, out_ready,
    input  in_ready, out_valid, plane_p, plane_n, bit_idx, first, last, busy
  );

  modport slave (
    input  in_valid, twos, unsigned_inputs, msb_first, precision, out_ready,
    output in_ready, out_valid, plane_p, plane_n, bit_idx, first, last, busy
  );
endinterface

// File: rtl/twos_to_bipolar_serial.sv
// Splits a vector of two's-complement (or unsigned) words into positive and
// negative magnitude registers, then streams them out one bit-plane per
// handshake, MSB- or LSB-first, truncated to the requested precision.
module twos_to_bipolar_serial #(
  parameter int inBits   = 4,
  parameter int numLanes = 32,
  parameter int idxBits  = (inBits > 1) ? $clog2(inBits) : 1,
  parameter int precBits = $clog2(inBits + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  twos_to_bipolar_serial_if.slave bus
);

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  localparam logic [precBits-1:0] FULL_P = precBits'(inBits);

  state_t                             state_q, state_d;
  logic [numLanes-1:0][inBits-1:0]    mag_p_q, mag_n_q;
  logic [numLanes-1:0][inBits-1:0]    mag_p_d, mag_n_d;
  logic [inBits-1:0]                  word;
  logic [precBits-1:0]                p_eff_q, p_eff_d;
  logic [precBits-1:0]                cnt_q;
  logic [idxBits-1:0]                 idx_q, idx_start;
  logic                               msb_q;
  logic                               busy_w, last_w, advance, accept;

  assign busy_w  = (state_q == SHIFT);
  assign last_w  = busy_w && (cnt_q == p_eff_q - 1'b1);
  assign advance = busy_w && bus.out_ready;
  // A new vector can land on the same edge that retires the final plane.
  assign bus.in_ready = !rst && (!busy_w || (advance && last_w));
  assign accept  = bus.in_valid && bus.in_ready;

  assign bus.out_valid = busy_w;
  assign bus.busy      = busy_w;
  assign bus.first     = busy_w && (cnt_q == '0);
  assign bus.last      = last_w;
  assign bus.bit_idx   = idx_q;

  // Per-lane sign split; negative words become their magnitude modulo 2^inBits.
  always_comb begin
    mag_p_d = '0;
    mag_n_d = '0;
    word    = '0;
    for (int i = 0; i < numLanes; i++) begin
      word = bus.twos[i*inBits +: inBits];
      if (bus.unsigned_inputs || !word[inBits-1]) mag_p_d[i] = word;
      else                                        mag_n_d[i] = -word;
    end
  end

  // Clamp precision: zero or oversize means the full word; pick the start index.
  always_comb begin
    p_eff_d = bus.precision;
    if (bus.precision == '0 || bus.precision > FULL_P) p_eff_d = FULL_P;
    idx_start = bus.msb_first ? idxBits'(p_eff_d - 1'b1) : '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: enter SHIFT on accept, leave after the last plane unless refilled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (advance && last_w && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Magnitude capture on accept, plane counter/index stepping on each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_p_q <= '0;
      mag_n_q <= '0;
      p_eff_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      msb_q   <= 1'b0;
    end else if (accept) begin
      mag_p_q <= mag_p_d;
      mag_n_q <= mag_n_d;
      p_eff_q <= p_eff_d;
      cnt_q   <= '0;
      idx_q   <= idx_start;
      msb_q   <= bus.msb_first;
    end else if (advance && !last_w) begin
      cnt_q <= cnt_q + 1'b1;
      idx_q <= msb_q ? idx_q - 1'b1 : idx_q + 1'b1;
    end
  end

  // Current bit-plane, forced to zero whenever no transaction is active.
  always_comb begin
    bus.plane_p = '0;
    bus.plane_n = '0;
    for (int i = 0; i < numLanes; i++) begin
      if (busy_w) begin
        bus.plane_p[i] = mag_p_q[i][idx_q];
        bus.plane_n[i] = mag_n_q[i][idx_q];
      end
    end
  end

endmodule

// File: tb/tb_twos_to_bipolar_serial.sv
// Directed bench for twos_to_bipolar_serial with 16 lanes of 4-bit words.
module tb_twos_to_bipolar_serial;
  localparam int IN_BITS  = 4;
  localparam int LANES    = 16;
  localparam int IDX_BITS = 2;
  localparam int W        = 2*LANES + IDX_BITS + 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];

  twos_to_bipolar_serial_if #(.inBits(IN_BITS), .numLanes(LANES)) bus ();

  twos_to_bipolar_serial #(.inBits(IN_BITS), .numLanes(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [LANES*IN_BITS-1:0] t, input logic uns, input logic msb,
                      input logic [2:0] prec, input logic keep_valid);
    int n = 0;
    bus.twos            = t;
    bus.unsigned_inputs = uns;
    bus.msb_first       = msb;
    bus.precision       = prec;
    bus.in_valid        = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", bus.in_ready, 1);
    @(posedge clk); #1;
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  // One plane with out_ready high; in_ready must track last in that case.
  task automatic expect_plane(input string tag, input logic [LANES-1:0] p, input logic [LANES-1:0] n,
                              input logic [IDX_BITS-1:0] idx, input logic f, input logic l);
    @(negedge clk);
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_p"}, bus.plane_p, p);
    check({tag, "_n"}, bus.plane_n, n);
    check({tag, "_idx"}, bus.bit_idx, idx);
    check({tag, "_first"}, bus.first, f);
    check({tag, "_last"}, bus.last, l);
    check({tag, "_in_ready"}, bus.in_ready, l);
    @(posedge clk); #1;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard model ----------------
  function automatic logic [W-1:0] model_plane(input logic uns, input int b, input logic f, input logic l);
    logic [LANES-1:0] p;
    logic [LANES-1:0] n;
    int v, mp, mn;
    p = '0;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      v = i - 8;
      if (uns)        begin mp = v & 15; mn = 0;  end
      else if (v < 0) begin mp = 0;      mn = -v; end
      else            begin mp = v;      mn = 0;  end
      p[i] = mp[b];
      n[i] = mn[b];
    end
    return {p, n, IDX_BITS'(b), f, l};
  endfunction

  task automatic drain_random(input string tag, input int n_planes);
    int got = 0;
    int cyc = 0;
    logic held_valid = 1'b0;
    logic [W-1:0] held = '0;
    logic [W-1:0] cur;
    logic [W-1:0] exp;
    while (got < n_planes && cyc < 200) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.out_valid) begin
        cur = {bus.plane_p, bus.plane_n, bus.bit_idx, bus.first, bus.last};
        if (held_valid) check({tag, "_stall_hold"}, cur, held);
        if (bus.out_ready) begin
          exp = exp_q.pop_front();
          check({tag, "_plane"}, cur, exp);
          got++;
          held_valid = 1'b0;
        end else begin
          check({tag, "_stall_in_ready"}, bus.in_ready, 0);
          held       = cur;
          held_valid = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_count"}, got, n_planes);
    bus.out_ready = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [LANES*IN_BITS-1:0] ramp;
    rst                 = 1'b1;
    bus.in_valid        = 1'b0;
    bus.twos            = '0;
    bus.unsigned_inputs = 1'b0;
    bus.msb_first       = 1'b0;
    bus.precision       = '0;
    bus.out_ready       = 1'b1;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_p", bus.plane_p, 0);
    check("rst_n", bus.plane_n, 0);
    check("rst_idx", bus.bit_idx, 0);
    check("rst_first", bus.first, 0);
    check("rst_last", bus.last, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // lane0 = -3, lane1 = 5, signed, MSB first, 4 planes
    send(64'h5D, 1'b0, 1'b1, 3'd4, 1'b0);
    expect_plane("t1_0", 16'h0000, 16'h0000, 2'd3, 1'b1, 1'b0);
    expect_plane("t1_1", 16'h0002, 16'h0000, 2'd2, 1'b0, 1'b0);
    expect_plane("t1_2", 16'h0000, 16'h0001, 2'd1, 1'b0, 1'b0);
    expect_plane("t1_3", 16'h0002, 16'h0001, 2'd0, 1'b0, 1'b1);
    expect_idle("t1_idle");

    // lane0 = -8 signed LSB first, then the same word unsigned
    send(64'h8, 1'b0, 1'b0, 3'd4, 1'b0);
    expect_plane("neg8_0", 16'h0, 16'h0, 2'd0, 1'b1, 1'b0);
    expect_plane("neg8_1", 16'h0, 16'h0, 2'd1, 1'b0, 1'b0);
    expect_plane("neg8_2", 16'h0, 16'h0, 2'd2, 1'b0, 1'b0);
    expect_plane("neg8_3", 16'h0, 16'h1, 2'd3, 1'b0, 1'b1);
    expect_idle("neg8_idle");
    send(64'h8, 1'b1, 1'b0, 3'd4, 1'b0);
    expect_plane("uns8_0", 16'h0, 16'h0, 2'd0, 1'b1, 1'b0);
    expect_plane("uns8_1", 16'h0, 16'h0, 2'd1, 1'b0, 1'b0);
    expect_plane("uns8_2", 16'h0, 16'h0, 2'd2, 1'b0, 1'b0);
    expect_plane("uns8_3", 16'h1, 16'h0, 2'd3, 1'b0, 1'b1);
    expect_idle("uns8_idle");

    // precision 2, LSB first; mode inputs flipped after accept must not matter
    send(64'h7, 1'b0, 1'b0, 3'd2, 1'b0);
    bus.msb_first       = 1'b1;
    bus.precision       = 3'd4;
    bus.unsigned_inputs = 1'b1;
    expect_plane("p2_0", 16'h1, 16'h0, 2'd0, 1'b1, 1'b0);
    expect_plane("p2_1", 16'h1, 16'h0, 2'd1, 1'b0, 1'b1);
    expect_idle("p2_idle");

    // precision 0 means full width
    send(64'h7, 1'b0, 1'b0, 3'd0, 1'b0);
    expect_plane("p0_0", 16'h1, 16'h0, 2'd0, 1'b1, 1'b0);
    expect_plane("p0_1", 16'h1, 16'h0, 2'd1, 1'b0, 1'b0);
    expect_plane("p0_2", 16'h1, 16'h0, 2'd2, 1'b0, 1'b0);
    expect_plane("p0_3", 16'h0, 16'h0, 2'd3, 1'b0, 1'b1);
    expect_idle("p0_idle");

    // precision above inBits clamps to full width, MSB first
    send(64'h7, 1'b0, 1'b1, 3'd7, 1'b0);
    expect_plane("p7_0", 16'h0, 16'h0, 2'd3, 1'b1, 1'b0);
    expect_plane("p7_1", 16'h1, 16'h0, 2'd2, 1'b0, 1'b0);
    expect_plane("p7_2", 16'h1, 16'h0, 2'd1, 1'b0, 1'b0);
    expect_plane("p7_3", 16'h1, 16'h0, 2'd0, 1'b0, 1'b1);
    expect_idle("p7_idle");

    // precision 1: single plane is both first and last
    send(64'h7, 1'b0, 1'b1, 3'd1, 1'b0);
    expect_plane("p1_0", 16'h1, 16'h0, 2'd0, 1'b1, 1'b1);
    expect_idle("p1_idle");

    // Back-to-back: A = +1, B = -1, in_valid held high, no bubble
    send(64'h1, 1'b0, 1'b1, 3'd4, 1'b1);
    bus.twos = 64'hF;
    expect_plane("bb_a0", 16'h0, 16'h0, 2'd3, 1'b1, 1'b0);
    expect_plane("bb_a1", 16'h0, 16'h0, 2'd2, 1'b0, 1'b0);
    expect_plane("bb_a2", 16'h0, 16'h0, 2'd1, 1'b0, 1'b0);
    expect_plane("bb_a3", 16'h1, 16'h0, 2'd0, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    expect_plane("bb_b0", 16'h0, 16'h0, 2'd3, 1'b1, 1'b0);
    expect_plane("bb_b1", 16'h0, 16'h0, 2'd2, 1'b0, 1'b0);
    expect_plane("bb_b2", 16'h0, 16'h0, 2'd1, 1'b0, 1'b0);
    expect_plane("bb_b3", 16'h0, 16'h1, 2'd0, 1'b0, 1'b1);
    expect_idle("bb_idle");

    // Random stalls: lanes hold -8..7, signed LSB first then unsigned MSB first
    ramp = '0;
    for (int i = 0; i < LANES; i++) ramp[i*IN_BITS +: IN_BITS] = 4'(i - 8);
    for (int b = 0; b < 4; b++) exp_q.push_back(model_plane(1'b0, b, b == 0, b == 3));
    send(ramp, 1'b0, 1'b0, 3'd4, 1'b0);
    drain_random("sb_signed", 4);
    expect_idle("sb_signed_idle");
    for (int b = 3; b >= 0; b--) exp_q.push_back(model_plane(1'b1, b, b == 3, b == 0));
    send(ramp, 1'b1, 1'b1, 3'd4, 1'b0);
    drain_random("sb_unsigned", 4);
    expect_idle("sb_unsigned_idle");
    check("sb_queue_empty", exp_q.size(), 0);

    // Reset on the second plane aborts the transaction
    send(64'h5D, 1'b0, 1'b1, 3'd4, 1'b0);
    expect_plane("rs_0", 16'h0, 16'h0, 2'd3, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rs_in_ready_hi", bus.in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rs_valid", bus.out_valid, 0);
    check("rs_busy", bus.busy, 0);
    check("rs_p", bus.plane_p, 0);
    check("rs_n", bus.plane_n, 0);
    check("rs_idx", bus.bit_idx, 0);
    check("rs_first", bus.first, 0);
    check("rs_last", bus.last, 0);
    check("rs_in_ready_held", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rs_in_ready_after", bus.in_ready, 1);
    check("rs_valid_after", bus.out_valid, 0);
    @(posedge clk); #1;

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
